// File: rtl/mux_pipe_sel_if.sv
// Bus bundle for mux_pipe_sel: input beat (select + data), output beat,
// flush/error-clear controls and status outputs.
interface mux_pipe_sel_if #(
    parameter int WIDTH     = 32,
    parameter int NUM_IN    = 4,
    parameter int SEL_W     = 3,
    parameter int ERR_CNT_W = 8
);
    logic [SEL_W-1:0]        sel;
    logic [NUM_IN*WIDTH-1:0] in_data;
    logic                    in_valid;
    logic                    in_ready;
    logic                    flush;
    logic [WIDTH-1:0]        out_data;
    logic                    out_valid;
    logic                    out_ready;
    logic                    err_clr;
    logic                    sel_err;
    logic [ERR_CNT_W-1:0]    err_cnt;
    logic [1:0]              occ;

    // Block side
    modport slave (
        input  sel, in_data, in_valid, flush, out_ready, err_clr,
        output in_ready, out_data, out_valid, sel_err, err_cnt, occ
    );

    // Driver / consumer side
    modport master (
        output sel, in_data, in_valid, flush, out_ready, err_clr,
        input  in_ready, out_data, out_valid, sel_err, err_cnt, occ
    );
endinterface

// File: rtl/mux_pipe_sel.sv
// NUM_IN-way WIDTH-bit select mux feeding a 2-entry registered output stage
// (head + skid) with valid/ready handshake. Out-of-range selects are consumed,
// never buffered, and recorded in a sticky flag plus a saturating counter.
module mux_pipe_sel #(
    parameter int WIDTH     = 32,
    parameter int NUM_IN    = 4,
    parameter int SEL_W     = 3,
    parameter int ERR_CNT_W = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    mux_pipe_sel_if.slave  bus
);

    if (NUM_IN < 2 || NUM_IN > (2 ** SEL_W)) begin : g_param_check
        $error("mux_pipe_sel: NUM_IN must lie in 2..2**SEL_W");
    end

    // Occupancy states; the encoding doubles as the occ output.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_e;

    // Select limit widened by one bit so the compare sees every sel bit.
    localparam logic [SEL_W:0] NUM_IN_EXT = (SEL_W + 1)'(NUM_IN);

    state_e                 state_q, state_d;
    logic [WIDTH-1:0]       head_q, head_d;
    logic [WIDTH-1:0]       skid_q, skid_d;
    logic                   sel_err_q, sel_err_d;
    logic [ERR_CNT_W-1:0]   err_cnt_q, err_cnt_d;

    logic [WIDTH-1:0]       mux_data;
    logic                   sel_bad;
    logic                   in_ready;
    logic                   out_valid;
    logic                   accept;
    logic                   pop;
    logic                   good_acc;
    logic                   bad_acc;

    // Saturating increment for the bad-select counter.
    function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    // Handshake qualifiers derive from registered state only, so there is
    // no combinational path from out_ready to in_ready.
    assign in_ready  = (state_q != FULL);
    assign out_valid = (state_q != EMPTY);
    assign sel_bad   = ({1'b0, bus.sel} >= NUM_IN_EXT);
    assign accept    = bus.in_valid & in_ready;
    assign pop       = out_valid & bus.out_ready;
    assign good_acc  = accept & ~sel_bad;
    assign bad_acc   = accept & sel_bad;

    // Full-width select decode; an out-of-range select yields zero, never X/Z.
    always_comb begin
        mux_data = '0;
        for (int k = 0; k < NUM_IN; k++) begin
            if (bus.sel == SEL_W'(k)) begin
                mux_data = bus.in_data[k*WIDTH +: WIDTH];
            end
        end
    end

    // Occupancy FSM next state and entry updates; flush discards everything,
    // including a beat accepted in the same cycle.
    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        skid_d  = skid_q;
        if (bus.flush) begin
            state_d = EMPTY;
        end else begin
            unique case (state_q)
                EMPTY: begin
                    if (good_acc) begin
                        state_d = ONE;
                        head_d  = mux_data;
                    end
                end
                ONE: begin
                    if (good_acc && !pop) begin
                        state_d = FULL;
                        skid_d  = mux_data;
                    end else if (good_acc && pop) begin
                        head_d  = mux_data;
                    end else if (pop) begin
                        state_d = EMPTY;
                    end
                end
                FULL: begin
                    if (pop) begin
                        state_d = ONE;
                        head_d  = skid_q;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    // Error tracking: a bad-select accept wins over a coincident clear,
    // and flush has no influence here.
    always_comb begin
        sel_err_d = sel_err_q;
        err_cnt_d = err_cnt_q;
        if (bad_acc) begin
            sel_err_d = 1'b1;
            err_cnt_d = bus.err_clr ? ERR_CNT_W'(1) : sat_inc(err_cnt_q);
        end else if (bus.err_clr) begin
            sel_err_d = 1'b0;
            err_cnt_d = '0;
        end
    end

    // State, head entry and error registers; head is reset so out_data reads 0.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= EMPTY;
            head_q    <= '0;
            sel_err_q <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            head_q    <= head_d;
            sel_err_q <= sel_err_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    // Skid entry is pure data and only meaningful while FULL.
    always_ff @(posedge clk) begin
        skid_q <= skid_d;
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.out_data  = head_q;
    assign bus.sel_err   = sel_err_q;
    assign bus.err_cnt   = err_cnt_q;
    assign bus.occ       = state_q;

endmodule

// File: tb/tb_mux_pipe_sel.sv
// Bench for mux_pipe_sel: queue-based model checked every cycle plus
// directed scenarios with literal expectations.
module tb_mux_pipe_sel;

    localparam int W    = 32;
    localparam int N    = 4;
    localparam int SW   = 3;
    localparam int EW   = 2;
    localparam int CMAX = 3;

    logic clk = 1'b0;
    logic rst_n;

    int n_total = 0;
    int n_bad   = 0;

    mux_pipe_sel_if #(.WIDTH(W), .NUM_IN(N), .SEL_W(SW), .ERR_CNT_W(EW)) bif ();

    mux_pipe_sel #(.WIDTH(W), .NUM_IN(N), .SEL_W(SW), .ERR_CNT_W(EW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bif.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [W-1:0] mq[$];
    int           m_cnt;
    bit           m_err;
    bit           model_ok = 1'b0;

    always @(posedge clk) begin
        int  sz;
        int  s;
        bit  acc;
        bit  pp;
        bit  bad;
        if (!rst_n) begin
            mq.delete();
            m_cnt    = 0;
            m_err    = 1'b0;
            model_ok = 1'b1;
        end else begin
            sz  = mq.size();
            s   = int'(bif.sel);
            acc = bif.in_valid && (sz < 2);
            pp  = (sz > 0) && bif.out_ready;
            bad = (s >= N);
            if (pp) void'(mq.pop_front());
            if (bif.flush) mq.delete();
            else if (acc && !bad) mq.push_back(bif.in_data[s*W +: W]);
            if (acc && bad) begin
                m_err = 1'b1;
                m_cnt = bif.err_clr ? 1 : ((m_cnt < CMAX) ? m_cnt + 1 : CMAX);
            end else if (bif.err_clr) begin
                m_err = 1'b0;
                m_cnt = 0;
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (model_ok) begin
            chk("m_occ", 64'(bif.occ), 64'(mq.size()));
            chk("m_out_valid", 64'(bif.out_valid), 64'(mq.size() > 0));
            chk("m_in_ready", 64'(bif.in_ready), 64'(mq.size() < 2));
            if (mq.size() > 0) chk("m_out_data", 64'(bif.out_data), 64'(mq[0]));
            chk("m_sel_err", 64'(bif.sel_err), 64'(m_err));
            chk("m_err_cnt", 64'(bif.err_cnt), 64'(m_cnt));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic [W-1:0] a0, input logic [W-1:0] a1,
                          input logic [W-1:0] a2, input logic [W-1:0] a3);
        bif.in_data = {a3, a2, a1, a0};
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n         = 1'b0;
        bif.sel       = '0;
        bif.in_data   = '0;
        bif.in_valid  = 1'b0;
        bif.flush     = 1'b0;
        bif.out_ready = 1'b0;
        bif.err_clr   = 1'b0;
        step();
        step();
        chk("rst_occ", 64'(bif.occ), 64'd0);
        chk("rst_out_valid", 64'(bif.out_valid), 64'd0);
        chk("rst_out_data", 64'(bif.out_data), 64'd0);
        chk("rst_in_ready", 64'(bif.in_ready), 64'd1);
        chk("rst_sel_err", 64'(bif.sel_err), 64'd0);
        chk("rst_err_cnt", 64'(bif.err_cnt), 64'd0);
        rst_n = 1'b1;
        step();

        // 1: single beat through an empty stage
        set_in(32'h0, 32'h1, 32'hDEADBEEF, 32'h3);
        bif.sel = 3'd2; bif.in_valid = 1'b1; bif.out_ready = 1'b1;
        step();
        bif.in_valid = 1'b0;
        chk("t1_out_valid", 64'(bif.out_valid), 64'd1);
        chk("t1_out_data", 64'(bif.out_data), 64'hDEADBEEF);
        chk("t1_occ", 64'(bif.occ), 64'd1);
        step();
        chk("t1_drain_occ", 64'(bif.occ), 64'd0);

        // 2: backpressure, A/B buffered, C waits
        bif.out_ready = 1'b0; bif.sel = 3'd0; bif.in_valid = 1'b1;
        set_in(32'hA, 32'h0, 32'h0, 32'h0);
        step();
        set_in(32'hB, 32'h0, 32'h0, 32'h0);
        step();
        set_in(32'hC, 32'h0, 32'h0, 32'h0);
        chk("t2_occ_full", 64'(bif.occ), 64'd2);
        chk("t2_in_ready", 64'(bif.in_ready), 64'd0);
        chk("t2_head_a", 64'(bif.out_data), 64'hA);
        step();
        chk("t2_hold_a", 64'(bif.out_data), 64'hA);
        chk("t2_still_full", 64'(bif.occ), 64'd2);
        bif.out_ready = 1'b1;
        step();
        chk("t2_out_b", 64'(bif.out_data), 64'hB);
        chk("t2_occ_one", 64'(bif.occ), 64'd1);
        step();
        bif.in_valid = 1'b0;
        chk("t2_out_c", 64'(bif.out_data), 64'hC);
        step();
        chk("t2_empty", 64'(bif.occ), 64'd0);

        // 3: streaming, one beat per cycle with sel cycling 0..3
        bif.in_valid = 1'b1;
        for (int i = 0; i < 16; i++) begin
            bif.sel = SW'(i % 4);
            set_in(32'h1000*i + 0, 32'h1000*i + 1, 32'h1000*i + 2, 32'h1000*i + 3);
            step();
            chk("t3_stream_data", 64'(bif.out_data), 64'(32'h1000*i + (i % 4)));
            chk("t3_stream_occ", 64'(bif.occ), 64'd1);
        end
        bif.in_valid = 1'b0;
        step();
        chk("t3_empty", 64'(bif.occ), 64'd0);

        // 4: out-of-range selects
        bif.in_valid = 1'b1; bif.sel = 3'd5;
        step();
        chk("t4_no_beat", 64'(bif.out_valid), 64'd0);
        chk("t4_sel_err", 64'(bif.sel_err), 64'd1);
        chk("t4_cnt1", 64'(bif.err_cnt), 64'd1);
        bif.sel = 3'd4;
        step();
        bif.sel = 3'd7;
        step();
        step();
        step();
        chk("t4_cnt_sat", 64'(bif.err_cnt), 64'd3);
        chk("t4_occ", 64'(bif.occ), 64'd0);
        bif.err_clr = 1'b1;
        step();
        chk("t4_clr_vs_bad", 64'(bif.err_cnt), 64'd1);
        chk("t4_clr_vs_bad_flag", 64'(bif.sel_err), 64'd1);
        bif.in_valid = 1'b0;
        step();
        bif.err_clr = 1'b0;
        chk("t4_clr_cnt", 64'(bif.err_cnt), 64'd0);
        chk("t4_clr_flag", 64'(bif.sel_err), 64'd0);
        bif.in_valid = 1'b1; bif.sel = 3'd3;
        set_in(32'h0, 32'h0, 32'h0, 32'h33);
        step();
        bif.in_valid = 1'b0;
        chk("t4_good_after", 64'(bif.out_data), 64'h33);
        step();

        // 5: flush while full, then while one entry with accept, then with bad select
        bif.out_ready = 1'b0; bif.sel = 3'd1; bif.in_valid = 1'b1;
        set_in(32'h0, 32'h50, 32'h0, 32'h0);
        step();
        set_in(32'h0, 32'h51, 32'h0, 32'h0);
        step();
        chk("t5_full", 64'(bif.occ), 64'd2);
        set_in(32'h0, 32'h52, 32'h0, 32'h0);
        bif.flush = 1'b1;
        step();
        bif.flush = 1'b0; bif.in_valid = 1'b0;
        chk("t5_flush_occ", 64'(bif.occ), 64'd0);
        chk("t5_flush_valid", 64'(bif.out_valid), 64'd0);
        chk("t5_flush_ready", 64'(bif.in_ready), 64'd1);
        bif.out_ready = 1'b1;
        step();
        chk("t5_nothing_out", 64'(bif.out_valid), 64'd0);
        bif.out_ready = 1'b0; bif.in_valid = 1'b1;
        set_in(32'h0, 32'h53, 32'h0, 32'h0);
        step();
        set_in(32'h0, 32'h54, 32'h0, 32'h0);
        bif.flush = 1'b1;
        step();
        chk("t5_flush_acc_occ", 64'(bif.occ), 64'd0);
        bif.sel = 3'd6;
        step();
        bif.flush = 1'b0; bif.in_valid = 1'b0;
        chk("t5_flush_bad_err", 64'(bif.sel_err), 64'd1);
        chk("t5_flush_bad_cnt", 64'(bif.err_cnt), 64'd1);
        chk("t5_flush_bad_occ", 64'(bif.occ), 64'd0);
        step();

        // 6: reset mid-stream at occ=2 with sel_err set
        bif.in_valid = 1'b1; bif.sel = 3'd0;
        set_in(32'h60, 32'h0, 32'h0, 32'h0);
        step();
        set_in(32'h61, 32'h0, 32'h0, 32'h0);
        step();
        chk("t6_pre_occ", 64'(bif.occ), 64'd2);
        chk("t6_pre_err", 64'(bif.sel_err), 64'd1);
        rst_n = 1'b0; bif.flush = 1'b1; bif.err_clr = 1'b1; bif.out_ready = 1'b1;
        step();
        chk("t6_occ", 64'(bif.occ), 64'd0);
        chk("t6_out_valid", 64'(bif.out_valid), 64'd0);
        chk("t6_out_data", 64'(bif.out_data), 64'd0);
        chk("t6_in_ready", 64'(bif.in_ready), 64'd1);
        chk("t6_sel_err", 64'(bif.sel_err), 64'd0);
        chk("t6_err_cnt", 64'(bif.err_cnt), 64'd0);
        rst_n = 1'b1; bif.flush = 1'b0; bif.err_clr = 1'b0; bif.in_valid = 1'b0;
        step();
        chk("t6_after", 64'(bif.occ), 64'd0);
        step();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
